// File: rtl/dcfifo_wr_arbiter.sv
// rtl/dcfifo_wr_arbiter.sv - round-robin, packet-locked write-port arbiter for a dual-clock FIFO
module dcfifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 512,
   parameter int ADDR_WIDTH = 3,
   parameter int HEADROOM   = 0,
   parameter int MAX_BEATS  = 16,
   parameter int ID_W       = 2
) (
   input  logic                     wrclk,
   input  logic                     aclr,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         fifo_data,
   output logic                     fifo_wrreq,
   input  logic                     fifo_wrfull,
   input  logic [ADDR_WIDTH:0]      fifo_wrusedw,
   output logic [ID_W-1:0]          grant_id,
   output logic                     busy,
   output logic                     err_overrun
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [ADDR_WIDTH+1:0] SPACE_LIMIT = (ADDR_WIDTH+2)'((2**ADDR_WIDTH) - HEADROOM);
   localparam logic [CNT_W-1:0]      LAST_CNT    = CNT_W'(MAX_BEATS - 1);
   localparam logic [ID_W-1:0]       LAST_ID     = ID_W'(NUM_REQ - 1);
   localparam logic [ID_W:0]         NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]       grant_nxt, pick, next_id;
   logic [ID_W:0]         idx_sum;
   logic [CNT_W-1:0]      beat_cnt;
   logic [2*NUM_REQ-1:0]  rot_valid;
   logic [ADDR_WIDTH+1:0] used_sum;
   logic [WIDTH-1:0]      sel_data;
   logic                  sel_valid, sel_last;
   logic                  pick_found, space_ok, accept, overrun_hit;

   // Room check: the write issued last edge is not yet visible in wrusedw, so count it
   always_comb begin
      used_sum = {1'b0, fifo_wrusedw} + {{(ADDR_WIDTH+1){1'b0}}, fifo_wrreq};
      space_ok = !fifo_wrfull && (used_sum < SPACE_LIMIT);
   end

   // Round-robin search: first valid source at or after rr_ptr, wrapping at NUM_REQ
   always_comb begin
      rot_valid  = {req_valid, req_valid} >> rr_ptr;
      pick_found = 1'b0;
      pick       = '0;
      idx_sum    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx_sum >= NUM_REQ_EXT) begin
               idx_sum = idx_sum - NUM_REQ_EXT;
            end
            pick_found = 1'b1;
            pick       = idx_sum[ID_W-1:0];
         end
      end
   end

   // Select the current owner's beat, valid and last flags
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_data  = req_data[i*WIDTH +: WIDTH];
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
         end
      end
      next_id = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
   end

   // Next-state and handshake logic: grant in IDLE, stream and release in LOCK
   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant_id;
      rr_ptr_nxt  = rr_ptr;
      req_ready   = '0;
      accept      = 1'b0;
      overrun_hit = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = LOCK;
               grant_nxt = pick;
            end
         end
         LOCK: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = (grant_id == ID_W'(i)) && space_ok;
            end
            accept = sel_valid && space_ok;
            if (accept && (sel_last || (beat_cnt == LAST_CNT))) begin
               state_nxt   = IDLE;
               rr_ptr_nxt  = next_id;
               overrun_hit = !sel_last;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge wrclk or posedge aclr) begin
      if (aclr) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arbitration bookkeeping: pointer, owner, per-packet beat count, sticky overrun
   always_ff @(posedge wrclk or posedge aclr) begin
      if (aclr) begin
         rr_ptr      <= '0;
         grant_id    <= '0;
         beat_cnt    <= '0;
         err_overrun <= 1'b0;
      end else begin
         rr_ptr   <= rr_ptr_nxt;
         grant_id <= grant_nxt;
         if (state == IDLE) begin
            beat_cnt <= '0;
         end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (overrun_hit) begin
            err_overrun <= 1'b1;
         end
      end
   end

   // Registered FIFO write port; data holds between writes
   always_ff @(posedge wrclk or posedge aclr) begin
      if (aclr) begin
         fifo_wrreq <= 1'b0;
         fifo_data  <= '0;
      end else begin
         fifo_wrreq <= accept;
         if (accept) begin
            fifo_data <= sel_data;
         end
      end
   end

   assign busy = (state == LOCK);

endmodule

// File: tb/tb_dcfifo_wr_arbiter.sv
// tb/tb_dcfifo_wr_arbiter.sv - self-checking bench for dcfifo_wr_arbiter
`timescale 1ns/1ps
module tb_dcfifo_wr_arbiter;

   localparam int NR    = 4;
   localparam int W     = 32;
   localparam int AW    = 3;
   localparam int HR    = 2;
   localparam int MB    = 16;
   localparam int IDW   = 2;
   localparam int DEPTH = 8;
   localparam int QD    = 64;

   logic            wrclk = 1'b0;
   logic            aclr;
   logic [NR-1:0]   req_valid, req_last, req_ready;
   logic [NR*W-1:0] req_data;
   logic [W-1:0]    fifo_data;
   logic            fifo_wrreq, fifo_wrfull, busy, err_overrun;
   logic [AW:0]     fifo_wrusedw;
   logic [IDW-1:0]  grant_id;

   dcfifo_wr_arbiter #(
      .NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW), .HEADROOM(HR), .MAX_BEATS(MB), .ID_W(IDW)
   ) dut (
      .wrclk(wrclk), .aclr(aclr),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq),
      .fifo_wrfull(fifo_wrfull), .fifo_wrusedw(fifo_wrusedw),
      .grant_id(grant_id), .busy(busy), .err_overrun(err_overrun)
   );

   // Write clock
   always #5 wrclk = ~wrclk;

   typedef struct {
      logic [AW:0] usedw;
      logic        full;
      logic        exp_ok;
   } vec_t;
   vec_t tbl[8];

   int n_tot = 0;
   int n_bad = 0;

   // Per-source beat queues (circular, head/tail counters)
   logic [W-1:0] q_data [NR][QD];
   logic         q_last [NR][QD];
   int           q_head [NR];
   int           q_tail [NR];
   logic [NR-1:0] src_en;

   // Reference model state
   bit           m_lock, m_pend, m_err;
   int           m_owner, m_ptr, m_cnt;
   logic [W-1:0] m_data;

   // Logs of observed writes and grants
   logic [W-1:0] wr_log [256];
   int           wr_cyc [256];
   int           gr_log [64];
   int           n_wr, n_gr, cyc;
   bit           prev_busy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_tot++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic push_beat(input int s, input logic [W-1:0] d, input logic l);
      q_data[s][q_tail[s] % QD] = d;
      q_last[s][q_tail[s] % QD] = l;
      q_tail[s]++;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NR; i++) begin
         if (src_en[i] && (q_tail[i] > q_head[i])) begin
            req_valid[i]         = 1'b1;
            req_data[i*W +: W]   = q_data[i][q_head[i] % QD];
            req_last[i]          = q_last[i][q_head[i] % QD];
         end else begin
            req_valid[i]         = 1'b0;
            req_data[i*W +: W]   = $urandom;
            req_last[i]          = 1'($urandom);
         end
      end
   endtask

   // Check outputs against the model, then advance the model across one clock edge
   task automatic model_cycle();
      bit            space, hit, lst;
      int            idx;
      logic [NR-1:0] exp_rdy;
      space   = !fifo_wrfull && ((int'(fifo_wrusedw) + int'(m_pend)) < (DEPTH - HR));
      exp_rdy = (m_lock && space) ? NR'(1 << m_owner) : '0;
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      chk("wrreq", 32'(fifo_wrreq), 32'(m_pend));
      if (m_pend) chk("data", fifo_data, m_data);
      chk("busy", 32'(busy), 32'(m_lock));
      if (m_lock) chk("grant_id", 32'(grant_id), m_owner);
      chk("err_overrun", 32'(err_overrun), 32'(m_err));
      if (fifo_wrreq && n_wr < 256) begin
         wr_log[n_wr] = fifo_data;
         wr_cyc[n_wr] = cyc;
         n_wr++;
      end
      if (busy && !prev_busy && n_gr < 64) begin
         gr_log[n_gr] = int'(grant_id);
         n_gr++;
      end
      prev_busy = busy;
      if (!m_lock) begin
         m_pend = 1'b0;
         hit    = 1'b0;
         for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (!hit && req_valid[idx]) begin
               hit     = 1'b1;
               m_owner = idx;
            end
         end
         if (hit) begin
            m_lock = 1'b1;
            m_cnt  = 0;
         end
      end else if (req_valid[m_owner] && space) begin
         m_pend = 1'b1;
         m_data = q_data[m_owner][q_head[m_owner] % QD];
         lst    = q_last[m_owner][q_head[m_owner] % QD];
         q_head[m_owner]++;
         m_cnt++;
         if (lst || m_cnt == MB) begin
            if (!lst) m_err = 1'b1;
            m_lock = 1'b0;
            m_ptr  = (m_owner + 1) % NR;
         end
      end else begin
         m_pend = 1'b0;
      end
      cyc++;
   endtask

   task automatic step();
      drive_inputs();
      @(negedge wrclk);
      model_cycle();
      @(posedge wrclk);
      #1;
   endtask

   // Asynchronous reset pulse with immediate output checks; pending beats are dropped
   task automatic do_reset(input string tag);
      aclr = 1'b1;
      #1;
      chk({tag, "_rst_wrreq"}, 32'(fifo_wrreq), 32'd0);
      chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rst_err"}, 32'(err_overrun), 32'd0);
      chk({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_rst_grant"}, 32'(grant_id), 32'd0);
      chk({tag, "_rst_data"}, fifo_data, 32'd0);
      @(posedge wrclk);
      #1;
      aclr = 1'b0;
      m_lock = 0; m_pend = 0; m_err = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      prev_busy = 0;
      for (int i = 0; i < NR; i++) q_head[i] = q_tail[i];
   endtask

   initial begin
      int cnt, len;
      bit seen1;
      logic [W-1:0] exp_wr [5];

      tbl[0] = '{4'd0, 1'b0, 1'b1};
      tbl[1] = '{4'd4, 1'b0, 1'b1};
      tbl[2] = '{4'd5, 1'b0, 1'b1};
      tbl[3] = '{4'd6, 1'b0, 1'b0};
      tbl[4] = '{4'd7, 1'b0, 1'b0};
      tbl[5] = '{4'd8, 1'b0, 1'b0};
      tbl[6] = '{4'd0, 1'b1, 1'b0};
      tbl[7] = '{4'd5, 1'b1, 1'b0};

      aclr = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
      fifo_wrfull = 1'b0; fifo_wrusedw = '0; src_en = '0;
      for (int i = 0; i < NR; i++) begin q_head[i] = 0; q_tail[i] = 0; end
      m_lock = 0; m_pend = 0; m_err = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_data = '0;
      n_wr = 0; n_gr = 0; cyc = 0; prev_busy = 0;
      #2;
      do_reset("init");

      // Room table: lock on req3 with its valid dropped, sweep wrusedw/wrfull
      push_beat(3, 32'h3000_0000, 1'b1);
      src_en = 4'b1000;
      step();
      src_en = 4'b0000;
      for (int t = 0; t < 8; t++) begin
         fifo_wrusedw = tbl[t].usedw;
         fifo_wrfull  = tbl[t].full;
         drive_inputs();
         @(negedge wrclk);
         chk($sformatf("space_vec%0d", t), 32'(req_ready), tbl[t].exp_ok ? 32'h8 : 32'h0);
         chk($sformatf("stall_busy%0d", t), 32'(busy), 32'd1);
         @(posedge wrclk);
         #1;
      end

      // wrfull with wrusedw=0: nothing written until full clears
      fifo_wrfull = 1'b1; fifo_wrusedw = '0; src_en = 4'b1000; n_wr = 0;
      repeat (4) step();
      chk("full_no_wrreq", n_wr, 0);
      fifo_wrfull = 1'b0;
      repeat (3) step();
      chk("full_drain", n_wr, 1);

      // Round robin: all four valid with one-beat packets
      do_reset("rr");
      n_wr = 0; n_gr = 0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < NR; i++) push_beat(i, W'((i << 24) | b), 1'b1);
      src_en = 4'hF;
      repeat (20) step();
      chk("rr_grant0", gr_log[0], 0);
      chk("rr_grant1", gr_log[1], 1);
      chk("rr_grant2", gr_log[2], 2);
      chk("rr_grant3", gr_log[3], 3);
      chk("rr_grant4", gr_log[4], 0);
      chk("rr_writes", n_wr, 8);
      chk("rr_wr4_src", 32'(wr_log[4] >> 24), 32'd0);

      // Packet lock: req1 holds the port for 3 beats while req0/req2 wait
      push_beat(0, 32'h0000_0001, 1'b1);
      src_en = 4'b0001;
      repeat (3) step();
      n_wr = 0; n_gr = 0;
      push_beat(0, 32'h0000_0010, 1'b1);
      push_beat(1, 32'h0100_0001, 1'b0);
      push_beat(1, 32'h0100_0002, 1'b0);
      push_beat(1, 32'h0100_0003, 1'b1);
      push_beat(2, 32'h0200_0010, 1'b1);
      src_en = 4'b0111;
      repeat (12) step();
      exp_wr = '{32'h0100_0001, 32'h0100_0002, 32'h0100_0003, 32'h0200_0010, 32'h0000_0010};
      for (int k = 0; k < 5; k++) chk($sformatf("lock_wr%0d", k), wr_log[k], exp_wr[k]);
      chk("lock_consecutive", wr_cyc[2] - wr_cyc[0], 2);
      chk("lock_grant_first", gr_log[0], 1);
      chk("lock_grant_next", gr_log[1], 2);

      // Backpressure: wrusedw=5 with one beat in flight stalls, 4 releases
      n_wr = 0;
      for (int b = 0; b < 4; b++) push_beat(0, W'(32'h0A00_0000 | b), (b == 3));
      src_en = 4'b0001; fifo_wrusedw = 4'd5;
      step();
      step();
      drive_inputs();
      #1;
      chk("bp_inflight", 32'(fifo_wrreq), 32'd1);
      chk("bp_stall", 32'(req_ready), 32'd0);
      fifo_wrusedw = 4'd4;
      #1;
      chk("bp_release", 32'(req_ready), 32'd1);
      repeat (8) step();
      chk("bp_beats", n_wr, 4);
      fifo_wrusedw = '0;

      // Overrun: 20 beats without last from req0, req1 waiting
      do_reset("ovr");
      n_wr = 0; n_gr = 0;
      for (int b = 0; b < 20; b++) push_beat(0, W'(b), 1'b0);
      push_beat(1, 32'h0100_00FF, 1'b1);
      src_en = 4'b0011;
      repeat (40) step();
      chk("ovr_err", 32'(err_overrun), 32'd1);
      cnt = 0; seen1 = 0;
      for (int k = 0; k < n_wr; k++) begin
         if ((wr_log[k] >> 24) == 32'd1) seen1 = 1;
         if (!seen1) cnt++;
      end
      chk("ovr_beats", cnt, 16);
      chk("ovr_next_grant", gr_log[1], 1);
      chk("ovr_still_locked", 32'(busy), 32'd1);

      // Reset mid-LOCK, then the next grant must go to req0
      do_reset("midlock");
      n_gr = 0;
      for (int i = 0; i < NR; i++) push_beat(i, W'(32'h5000_0000 | i), 1'b1);
      src_en = 4'hF;
      repeat (3) step();
      chk("post_reset_grant", gr_log[0], 0);
      repeat (10) step();

      // Randomised traffic with random stalls and FIFO fill levels
      repeat (1500) begin
         for (int i = 0; i < NR; i++) begin
            if ((q_tail[i] - q_head[i]) < 24 && $urandom_range(0, 9) == 0) begin
               len = $urandom_range(1, 6);
               for (int b = 0; b < len; b++) push_beat(i, $urandom, (b == len - 1));
            end
         end
         src_en       = NR'($urandom) | NR'($urandom);
         fifo_wrfull  = ($urandom_range(0, 9) == 0);
         fifo_wrusedw = (AW+1)'($urandom_range(0, 8));
         step();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   // Run-time bound
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
